// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions used by the transmit framer and the
//                receive deframer: FSM state encoding, frame bit positions,
//                parity encodings and the parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmit FSM states. The width is fixed so the encoding is stable across
  // tools and visible in waveforms.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  // Frame layout, transmitted from START_IDX down to STOP_IDX.
  localparam int FRAME_W    = 11;
  localparam int START_IDX  = 10;
  localparam int DATA_MSB   = 9;
  localparam int DATA_LSB   = 2;
  localparam int PARITY_IDX = 1;
  localparam int STOP_IDX   = 0;

  // parity_type encodings.
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic       ptype);
    return (^data) ^ (ptype == PARITY_ODD);
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period timer. Counts clock cycles and flags the last
//                cycle of every serial bit period.
//  Ports       : clock    - system clock, rising edge
//                reset    - synchronous active-high reset
//                clear    - hold the counter at zero (frame not running)
//                bit_tick - high on the last cycle of a bit period
//  Parameters  : CLKS_PER_BIT - clock cycles per serial bit, 2 or more
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The tick is decoded from the registered count, so the FSM sees it on the
  // final cycle of the period and moves on at the following edge.
  assign bit_tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame
//  Description : UART transmit framer and serialiser. Accepts one byte per
//                valid/ready handshake, builds the 11-bit frame
//                {start, data[7:0] MSB first, parity, stop} and shifts it out
//                on tx, one bit per CLKS_PER_BIT cycles. tx_done pulses for
//                one cycle when the frame completes.
//  Ports       : clock       - system clock, rising edge
//                reset       - synchronous active-high reset
//                tx_valid    - byte on tx_data is offered
//                tx_data     - byte to send, sampled on accept
//                parity_type - 0 even / 1 odd, sampled on accept
//                              (only with UART_TX_PARITY_EN)
//                tx_ready    - idle, a byte can be accepted
//                tx          - serial line, idles high
//                tx_busy     - frame in progress
//                tx_done     - one-cycle pulse after the stop bit
//  Parameters  : CLKS_PER_BIT - clock cycles per serial bit, 2 or more
//  Build macro : UART_TX_PARITY_EN - when defined, parity_type exists and the
//                parity slot carries computed parity; otherwise the slot is a
//                constant mark (1). Frame length is 11 bits either way.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic       parity_type,
`endif
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  uart_tx_state_t     state_q;
  uart_tx_state_t     state_d;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;
  logic [2:0]         bit_idx_q;
  logic [2:0]         bit_idx_d;
  logic               tx_q;
  logic               tx_d;
  logic               done_q;
  logic               done_d;

  logic               accept;
  logic               par_bit;
  logic               bit_tick;
  logic               baud_clear;
  logic [7:0]         data_bits;

  assign accept    = tx_valid && (state_q == ST_IDLE);
  assign data_bits = frame_q[DATA_MSB:DATA_LSB];

  // Parity is worked out from tx_data in the accept cycle, i.e. from exactly
  // the byte being captured, so later input changes cannot affect it.
`ifdef UART_TX_PARITY_EN
  assign par_bit = calc_parity(tx_data, parity_type);
`else
  assign par_bit = 1'b1;
`endif

  // Keeping the timer cleared while idle means every frame starts with a
  // fresh full-length start bit, whenever the accept happens.
  assign baud_clear = (state_q == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clock    (clock),
    .reset    (reset),
    .clear    (baud_clear),
    .bit_tick (bit_tick)
  );

  // Next-state logic. tx_d is the line value for the state being entered, so
  // the registered tx changes on the same edge as the state register and
  // every bit is held for exactly one bit period.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          frame_d[START_IDX]         = 1'b0;
          frame_d[DATA_MSB:DATA_LSB] = tx_data;
          frame_d[PARITY_IDX]        = par_bit;
          frame_d[STOP_IDX]          = 1'b1;
          bit_idx_d                  = 3'd7;
          tx_d                       = frame_d[START_IDX];
          state_d                    = ST_START;
        end
      end

      ST_START: begin
        if (bit_tick) begin
          tx_d    = data_bits[bit_idx_q];
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == 3'd0) begin
            tx_d    = frame_q[PARITY_IDX];
            state_d = ST_PARITY;
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
            tx_d      = data_bits[bit_idx_d];
          end
        end
      end

      ST_PARITY: begin
        if (bit_tick) begin
          tx_d    = frame_q[STOP_IDX];
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      frame_q   <= '1;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx       = tx_q;
  assign tx_done  = done_q;

endmodule : uart_tx_frame
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_frame
//  Description : Directed self-checking bench for uart_tx_frame with
//                CLKS_PER_BIT = 4. Works with or without UART_TX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

  localparam int CPB = 4;
  localparam int NBITS = 11;

  logic       clock;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       ptype;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int total;
  int bad;

  uart_tx_frame #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
`ifdef UART_TX_PARITY_EN
    .parity_type (ptype),
`endif
    .tx_ready    (tx_ready),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_parity(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
    return (^d) ^ p;
`else
    return 1'b1;
`endif
  endfunction

  // Called on the sample just after the accepting edge. Checks all 44 line
  // samples, scrambles the inputs mid-frame, and returns on the tx_done
  // sample (no further step).
  task automatic frame_check(input string tag, input logic [7:0] d, input logic p);
    logic [NBITS-1:0] exp_bits;
    exp_bits = {1'b0, d, exp_parity(d, p), 1'b1};
    for (int i = 0; i < NBITS * CPB; i++) begin
      check($sformatf("%s_bit%0d_c%0d", tag, i / CPB, i % CPB),
            {7'd0, tx}, {7'd0, exp_bits[NBITS - 1 - (i / CPB)]});
      if ((i % CPB) == 0) begin
        check($sformatf("%s_busy%0d", tag, i), {7'd0, tx_busy}, 8'd1);
        check($sformatf("%s_nodone%0d", tag, i), {7'd0, tx_done}, 8'd0);
      end
      if (i == 2) begin
        tx_data = ~d;
        ptype   = ~p;
      end
      step();
    end
    check({tag, "_done"}, {7'd0, tx_done}, 8'd1);
    check({tag, "_ready"}, {7'd0, tx_ready}, 8'd1);
    check({tag, "_idle_tx"}, {7'd0, tx}, 8'd1);
  endtask

  // Offer one byte from idle, check the frame, then confirm the done pulse
  // is exactly one cycle wide.
  task automatic send(input string tag, input logic [7:0] d, input logic p);
    tx_valid = 1'b1;
    tx_data  = d;
    ptype    = p;
    step();
    tx_valid = 1'b0;
    frame_check(tag, d, p);
    step();
    check({tag, "_done_clr"}, {7'd0, tx_done}, 8'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    ptype    = 1'b0;

    // Reset idle.
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check("rst_tx",    {7'd0, tx},       8'd1);
      check("rst_ready", {7'd0, tx_ready}, 8'd1);
      check("rst_busy",  {7'd0, tx_busy},  8'd0);
      check("rst_done",  {7'd0, tx_done},  8'd0);
      step();
    end

    // Parity frames.
    send("a5_even", 8'hA5, 1'b0);
    step();
    send("a5_odd", 8'hA5, 1'b1);
    step();
    send("00_odd", 8'h00, 1'b1);
    send("ff_even", 8'hFF, 1'b0);

    // Back-to-back with tx_valid held: frame_check leaves tx_data = ~0x3C =
    // 0xC3 and ptype = 1 pending, which must go out right after one idle cycle.
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    ptype    = 1'b0;
    step();
    frame_check("b2b_3c", 8'h3C, 1'b0);
    check("b2b_gap_ready", {7'd0, tx_ready}, 8'd1);
    step();
    tx_valid = 1'b0;
    frame_check("b2b_c3", 8'hC3, 1'b1);
    step();
    check("b2b_done_clr", {7'd0, tx_done}, 8'd0);

    // Mid-frame reset during the data bits.
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    ptype    = 1'b0;
    step();
    tx_valid = 1'b0;
    repeat (15) step();
    check("mid_busy", {7'd0, tx_busy}, 8'd1);
    reset = 1'b1;
    step();
    check("mid_rst_tx",    {7'd0, tx},       8'd1);
    check("mid_rst_ready", {7'd0, tx_ready}, 8'd1);
    check("mid_rst_busy",  {7'd0, tx_busy},  8'd0);
    check("mid_rst_done",  {7'd0, tx_done},  8'd0);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      check("mid_after_done", {7'd0, tx_done}, 8'd0);
      check("mid_after_tx",   {7'd0, tx},      8'd1);
      step();
    end
    send("post_81", 8'h81, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_tx_frame
`default_nettype wire
